// File: rtl/alu_seq_pkg.sv
// Shared types, control encodings and helper functions for the nibble-serial ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_AND = 3'd4,
        OP_XOR = 3'd5,
        OP_OR  = 3'd6,
        OP_CP  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice control words {R,S,V}
    localparam logic [2:0] RSV_ADD = 3'b000;
    localparam logic [2:0] RSV_XOR = 3'b100;
    localparam logic [2:0] RSV_AND = 3'b010;
    localparam logic [2:0] RSV_OR  = 3'b111;

    localparam int FLAG_SF  = 5;
    localparam int FLAG_ZF  = 4;
    localparam int FLAG_HF  = 3;
    localparam int FLAG_PVF = 2;
    localparam int FLAG_NF  = 1;
    localparam int FLAG_CF  = 0;

    function automatic logic is_sub(input alu_op_t op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    endfunction

    function automatic logic is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_ADC) || is_sub(op);
    endfunction

    function automatic logic [2:0] op_rsv(input alu_op_t op);
        logic [2:0] rsv;
        case (op)
            OP_XOR:  rsv = RSV_XOR;
            OP_AND:  rsv = RSV_AND;
            OP_OR:   rsv = RSV_OR;
            default: rsv = RSV_ADD;
        endcase
        return rsv;
    endfunction

    function automatic logic op_cin0(input alu_op_t op, input logic cf);
        logic cin;
        case (op)
            OP_ADC:  cin = cf;
            OP_SUB:  cin = 1'b1;
            OP_CP:   cin = 1'b1;
            OP_SBC:  cin = ~cf;
            OP_AND:  cin = 1'b1;
            default: cin = 1'b0;
        endcase
        return cin;
    endfunction

    // Zero-extension keeps parity, so one 16-bit helper covers every width.
    function automatic logic even_parity(input logic [15:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/alu_nibble.sv
// One-bit ALU slice and the 4-bit ripple chain of slices the sequencer drives once per pass.
module alu_slice
    import alu_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cy_in,
    input  logic [2:0] rsv,
    output logic       f,
    output logic       cy_out
);

    // Select sum/xor/and/or; only the adder propagates a carry.
    always_comb begin
        f      = 1'b0;
        cy_out = 1'b0;
        case (rsv)
            RSV_ADD: begin
                f      = a ^ b ^ cy_in;
                cy_out = (a & b) | (cy_in & (a ^ b));
            end
            RSV_XOR: f = a ^ b;
            RSV_AND: f = a & b;
            RSV_OR:  f = a | b;
            default: begin
                f      = 1'b0;
                cy_out = 1'b0;
            end
        endcase
    end

endmodule

module alu_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cy_in,
    input  logic [2:0] rsv,
    output logic [3:0] f,
    output logic       cy_out
);

    logic [4:0] carry_s;

    assign carry_s[0] = cy_in;
    assign cy_out     = carry_s[4];

    for (genvar i = 0; i < 4; i++) begin : g_slice
        alu_slice u_slice (
            .a      (a[i]),
            .b      (b[i]),
            .cy_in  (carry_s[i]),
            .rsv    (rsv),
            .f      (f[i]),
            .cy_out (carry_s[i+1])
        );
    end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Issues one op through a 4-bit ALU slice chain, LSB nibble first, and returns result plus Z80 flags.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PASSES = 2,
    localparam int DW = 4 * PASSES
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req_valid,
    output logic          req_ready,
    input  alu_op_t       req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    input  logic          req_cf,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_wr,
    output logic [5:0]    res_flags
);

    localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);

    state_t        state_r, state_next_s;
    logic [1:0]    pass_r;
    logic          carry_r, hc_r, cf_r;
    alu_op_t       op_r;
    logic [DW-1:0] a_r, b_r, acc_r, acc_next_s;
    logic [DW+3:0] acc_ext_s;
    logic [3:0]    f_s;
    logic          cy_in_s, cy_out_s, hc_s, last_s, sub_s;
    logic [5:0]    flags_s;

    // Operands shift right each pass, so the active nibble is always bits [3:0].
    assign cy_in_s    = (pass_r == 2'd0) ? op_cin0(op_r, cf_r) : carry_r;
    assign last_s     = (pass_r == LAST_PASS);
    assign acc_ext_s  = {f_s, acc_r};
    assign acc_next_s = acc_ext_s[DW+3:4];
    assign hc_s       = (pass_r == 2'd0) ? cy_out_s : hc_r;
    assign sub_s      = is_sub(op_r);

    alu_nibble u_nibble (
        .a      (a_r[3:0]),
        .b      (b_r[3:0]),
        .cy_in  (cy_in_s),
        .rsv    (op_rsv(op_r)),
        .f      (f_s),
        .cy_out (cy_out_s)
    );

    // Flags from the fully assembled result, meaningful during the last pass.
    always_comb begin
        flags_s           = 6'd0;
        flags_s[FLAG_SF]  = acc_next_s[DW-1];
        flags_s[FLAG_ZF]  = (acc_next_s == {DW{1'b0}});
        flags_s[FLAG_NF]  = sub_s;
        if (is_arith(op_r)) begin
            flags_s[FLAG_CF]  = cy_out_s ^ sub_s;
            flags_s[FLAG_HF]  = hc_s ^ sub_s;
            flags_s[FLAG_PVF] = (a_r[3] == b_r[3]) && (acc_next_s[DW-1] != a_r[3]);
        end else begin
            flags_s[FLAG_CF]  = 1'b0;
            flags_s[FLAG_HF]  = (op_r == OP_AND);
            flags_s[FLAG_PVF] = even_parity(16'(acc_next_s));
        end
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (req_valid) state_next_s = RUN;     else state_next_s = IDLE;
            RUN:     if (last_s)    state_next_s = DONE;    else state_next_s = RUN;
            DONE:    if (res_ready) state_next_s = IDLE;    else state_next_s = DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= {DW{1'b0}};
            res_flags <= 6'd0;
            res_wr    <= 1'b0;
            pass_r    <= 2'd0;
            carry_r   <= 1'b0;
            hc_r      <= 1'b0;
            cf_r      <= 1'b0;
            op_r      <= OP_ADD;
            a_r       <= {DW{1'b0}};
            b_r       <= {DW{1'b0}};
            acc_r     <= {DW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            req_ready <= (state_next_s == IDLE);
            res_valid <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        op_r   <= req_op;
                        a_r    <= req_a;
                        b_r    <= is_sub(req_op) ? ~req_b : req_b;
                        cf_r   <= req_cf;
                        pass_r <= 2'd0;
                        acc_r  <= {DW{1'b0}};
                    end
                end
                RUN: begin
                    a_r     <= a_r >> 3'd4;
                    b_r     <= b_r >> 3'd4;
                    acc_r   <= acc_next_s;
                    carry_r <= cy_out_s;
                    pass_r  <= pass_r + 2'd1;
                    if (pass_r == 2'd0) hc_r <= cy_out_s;
                    if (last_s) begin
                        res_data  <= acc_next_s;
                        res_flags <= flags_s;
                        res_wr    <= (op_r != OP_CP);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench: directed ops push expected results; a monitor checks each handed-off result.
module tb_alu_nibble_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       wr;
        logic [5:0] flags;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    alu_op_t    req_op = OP_ADD;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic       req_cf = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       res_wr;
    logic [5:0] res_flags;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   lat_done = 1'b0;

    alu_nibble_sequencer #(.PASSES(2)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cf    (req_cf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_wr    (res_wr),
        .res_flags (res_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one request at the next free slot; push=0 issues without expecting a result.
    task automatic issue(input alu_op_t op, input logic [7:0] a, input logic [7:0] b, input logic cf,
                         input logic [7:0] ed, input logic ew, input logic [5:0] ef, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        req_op = op; req_a = a; req_b = b; req_cf = cf; req_valid = 1'b1;
        e.data = ed; e.wr = ew; e.flags = ef; e.acc = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Monitor: latency of first valid, then full compare on hand-off.
    always @(negedge clk) begin
        if (!nreset) begin
            lat_done = 1'b0;
        end else if (res_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_result", 32'd1, 32'd0);
            end else begin
                if (!lat_done) begin
                    chk("latency", 32'(cyc - sb[0].acc), 32'd3);
                    lat_done = 1'b1;
                end
                if (res_ready) begin
                    chk("res_data",  32'(res_data),  32'(sb[0].data));
                    chk("res_wr",    32'(res_wr),    32'(sb[0].wr));
                    chk("res_flags", 32'(res_flags), 32'(sb[0].flags));
                    void'(sb.pop_front());
                    lat_done = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_flags", 32'(res_flags), 32'd0);
        chk("rst_res_wr",    32'(res_wr),    32'd0);
        nreset = 1'b1;

        // flags = {sf,zf,hf,pvf,nf,cf}
        issue(OP_ADD, 8'h3A, 8'hC6, 1'b0, 8'h00, 1'b1, 6'b011001, 1'b1);
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 6'b101100, 1'b1);
        issue(OP_SUB, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 6'b001010, 1'b1);
        issue(OP_SBC, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 6'b101011, 1'b1);
        issue(OP_CP,  8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 6'b010010, 1'b1);
        issue(OP_AND, 8'h5C, 8'hF0, 1'b0, 8'h50, 1'b1, 6'b001100, 1'b1);
        issue(OP_OR,  8'h03, 8'hC0, 1'b0, 8'hC3, 1'b1, 6'b100100, 1'b1);
        issue(OP_XOR, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 6'b010100, 1'b1);
        issue(OP_ADC, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b1, 6'b001000, 1'b1);

        // Backpressure: result must hold while res_ready is low.
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        res_ready = 1'b0;
        issue(OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 1'b1, 6'b000000, 1'b1);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data",  32'(res_data),  32'h46);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;

        // Reset during RUN discards the op.
        issue(OP_SUB, 8'h55, 8'h11, 1'b0, 8'h44, 1'b1, 6'b000010, 1'b0);
        nreset = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_res_data",  32'(res_data),  32'd0);
        chk("midrst_res_flags", 32'(res_flags), 32'd0);
        nreset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);

        // Throughput still intact after reset.
        issue(OP_OR, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 6'b010100, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_sb", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
